// File: rtl/fifo_packer.sv
// fifo_packer
//   Sits downstream of the team FIFO and pops narrow words from it, one at a
//   time. Every PACK consecutive words are assembled into one wide word,
//   which is offered on a valid/ready output. A flush request pushes out a
//   partially filled word together with its word count, so tail data never
//   waits forever for the rest of a word that is not coming.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   fifo_empty   : FIFO empty flag
//   fifo_dataOut : FIFO read data, valid on the edge after a pop
//   fifo_RD      : one-cycle registered pop request to the FIFO
//   flush        : level request to emit a partially filled word
//   out_data     : packed word, first popped word in the lowest slot
//   out_count    : number of valid words in out_data (1..PACK)
//   out_valid    : out_data/out_count are valid
//   out_ready    : downstream accepts when out_valid && out_ready at an edge
module fifo_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK       = 4,
  localparam int CNT_W     = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_dataOut,
  output logic                       fifo_RD,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    OUTPUT
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_nxt;
  logic [DATA_WIDTH*PACK-1:0] pack_reg;
  logic [DATA_WIDTH*PACK-1:0] pack_nxt;
  logic [CNT_W-1:0]           out_count_nxt;
  logic                       rd_nxt;
  logic                       valid_nxt;
  logic                       flush_pend;
  logic                       flush_pend_nxt;

  // The pack register is presented directly; slots not yet written stay 0
  // because the register is cleared on reset and after every handshake.
  assign out_data = pack_reg;

  // State and datapath registers. Every output is registered so fifo_RD is
  // a clean one-cycle pulse and out_* stay stable while waiting for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      pack_reg   <= '0;
      out_count  <= '0;
      fifo_RD    <= 1'b0;
      out_valid  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      pack_reg   <= pack_nxt;
      out_count  <= out_count_nxt;
      fifo_RD    <= rd_nxt;
      out_valid  <= valid_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  // Next-state and next-register logic. A flush seen while a word is in
  // flight (READ/CAPTURE) is remembered and honoured on the next IDLE visit,
  // so the word being fetched lands in the flushed output.
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    pack_nxt       = pack_reg;
    out_count_nxt  = out_count;
    rd_nxt         = 1'b0;
    valid_nxt      = out_valid;
    flush_pend_nxt = flush_pend;

    case (state)
      IDLE: begin
        if ((flush || flush_pend) && (count != '0)) begin
          state_nxt      = OUTPUT;
          valid_nxt      = 1'b1;
          out_count_nxt  = count;
          flush_pend_nxt = 1'b0;
        end else begin
          // Nothing buffered means nothing to flush: drop the request.
          if (count == '0) begin
            flush_pend_nxt = 1'b0;
          end
          if (!fifo_empty) begin
            state_nxt = READ;
            rd_nxt    = 1'b1;
          end
        end
      end

      READ: begin
        state_nxt = CAPTURE;
        if (flush) begin
          flush_pend_nxt = 1'b1;
        end
      end

      CAPTURE: begin
        for (int i = 0; i < PACK; i++) begin
          if (count == CNT_W'(i)) begin
            pack_nxt[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dataOut;
          end
        end
        count_nxt = count + CNT_W'(1);
        if (flush) begin
          flush_pend_nxt = 1'b1;
        end
        if (count == CNT_W'(PACK - 1)) begin
          state_nxt     = OUTPUT;
          valid_nxt     = 1'b1;
          out_count_nxt = CNT_W'(PACK);
        end else begin
          state_nxt = IDLE;
        end
      end

      OUTPUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          pack_nxt  = '0;
          count_nxt = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer
//   Drives fifo_packer from a small behavioural FIFO and scores the packed
//   output beats against expected words queued when the data is pushed.
module tb_fifo_packer;

  localparam int DW = 4;
  localparam int PK = 4;
  localparam int OW = DW * PK;
  localparam int CW = $clog2(PK + 1);

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] count;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dataOut = '0;
  logic          fifo_RD;
  logic          flush = 1'b0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready = 1'b0;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  beat_t         obs_q[$];

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int rd_run = 0;
  int rd_wide = 0;
  int underflow = 0;

  fifo_packer #(
    .DATA_WIDTH(DW),
    .PACK(PK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_dataOut(fifo_dataOut),
    .fifo_RD(fifo_RD),
    .flush(flush),
    .out_data(out_data),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO sharing the same reset: pops on an edge where fifo_RD
  // is high, read data appears after that edge.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_dataOut <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_RD && fifo_q.size() > 0) begin
        fifo_dataOut <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Output monitor: records accepted beats and fifo_RD pulse statistics.
  always @(negedge clk) begin
    if (rst) begin
      rd_run = 0;
    end else begin
      if (fifo_RD) begin
        rd_count++;
        rd_run++;
        if (rd_run > 1) rd_wide++;
        if (fifo_q.size() == 0) underflow++;
      end else begin
        rd_run = 0;
      end
      if (out_valid && out_ready) begin
        obs_q.push_back('{data: out_data, count: out_count});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
  endtask

  task automatic wait_beat(output bit got, output beat_t b);
    int budget;
    budget = 300;
    got = 1'b0;
    b = '0;
    while (obs_q.size() == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic wait_rd_pulses(input int n, output bit ok);
    int seen;
    int budget;
    seen = 0;
    budget = 200;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (fifo_RD) seen++;
      budget--;
    end
    ok = (seen == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (fifo_RD !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b want 0", fifo_RD); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", out_data); end
    checks++;
    if (out_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", out_count); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_full_word();
    bit    got;
    beat_t b;
    beat_t e;
    int    rd_base;
    int    wide_base;
    rd_base = rd_count;
    wide_base = rd_wide;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    exp_q.push_back('{data: 16'h4321, count: CW'(4)});
    wait_beat(got, b);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL full_beat: no beat seen, want %h/%0d", e.data, e.count); end
    else if (b !== e) begin errors++; $display("[TB] FAIL full_beat: got %h/%0d want %h/%0d", b.data, b.count, e.data, e.count); end
    cycles(4);
    checks++;
    if (rd_count - rd_base != 4) begin errors++; $display("[TB] FAIL full_rd_pulses: got %0d want 4", rd_count - rd_base); end
    checks++;
    if (rd_wide != wide_base) begin errors++; $display("[TB] FAIL full_rd_width: got %0d wide cycles want 0", rd_wide - wide_base); end
  endtask

  task automatic test_backpressure();
    bit    got;
    bit    seen_valid;
    beat_t b;
    beat_t e;
    int    budget;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    exp_q.push_back('{data: 16'h4321, count: CW'(4)});
    exp_q.push_back('{data: 16'h8765, count: CW'(4)});
    seen_valid = 1'b0;
    budget = 200;
    while (!seen_valid && budget > 0) begin
      @(negedge clk);
      seen_valid = out_valid;
      budget--;
    end
    checks++;
    if (!seen_valid) begin errors++; $display("[TB] FAIL bp_valid_rise: got 0 want 1"); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h4321 || fifo_RD !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold c=%0d: got valid=%b data=%h rd=%b want valid=1 data=4321 rd=0", c, out_valid, out_data, fifo_RD);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_beat(got, b);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL bp_beat%0d: no beat seen, want %h", k, e.data); end
      else if (b !== e) begin errors++; $display("[TB] FAIL bp_beat%0d: got %h/%0d want %h/%0d", k, b.data, b.count, e.data, e.count); end
    end
    cycles(4);
  endtask

  task automatic test_partial_flush();
    bit    got;
    beat_t b;
    beat_t e;
    int    budget;
    out_ready = 1'b1;
    push_word(4'h5);
    push_word(4'h6);
    exp_q.push_back('{data: 16'h0065, count: CW'(2)});
    budget = 100;
    while ((fifo_q.size() != 0 || !fifo_empty) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    cycles(6);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_beat(got, b);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL partial_beat: no beat seen, want %h/%0d", e.data, e.count); end
    else if (b !== e) begin errors++; $display("[TB] FAIL partial_beat: got %h/%0d want %h/%0d", b.data, b.count, e.data, e.count); end
    cycles(4);
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || fifo_RD !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_empty c=%0d: got valid=%b rd=%b want 0/0", c, out_valid, fifo_RD);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL flush_empty_beats: got %0d want 0", obs_q.size()); end
    cycles(1);
  endtask

  task automatic test_flush_capture();
    bit    got;
    bit    ok;
    beat_t b;
    beat_t e;
    out_ready = 1'b1;
    push_word(4'hA);
    push_word(4'hB);
    push_word(4'hC);
    exp_q.push_back('{data: 16'h0CBA, count: CW'(3)});
    wait_rd_pulses(3, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL flushcap_rd: got fewer than 3 pulses want 3"); end
    cycles(1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_beat(got, b);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL flushcap_beat: no beat seen, want %h/%0d", e.data, e.count); end
    else if (b !== e) begin errors++; $display("[TB] FAIL flushcap_beat: got %h/%0d want %h/%0d", b.data, b.count, e.data, e.count); end
    cycles(4);
  endtask

  task automatic test_reset_capture();
    bit    got;
    bit    ok;
    beat_t b;
    beat_t e;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    wait_rd_pulses(2, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rstcap_rd: got fewer than 2 pulses want 2"); end
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_RD !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstcap_state: got valid=%b rd=%b want 0/0", out_valid, fifo_RD);
    end
    cycles(2);
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    exp_q.push_back('{data: 16'h4321, count: CW'(4)});
    wait_beat(got, b);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL rstcap_beat: no beat seen, want %h/%0d", e.data, e.count); end
    else if (b !== e) begin errors++; $display("[TB] FAIL rstcap_beat: got %h/%0d want %h/%0d", b.data, b.count, e.data, e.count); end
    cycles(4);
  endtask

  task automatic test_final();
    checks++;
    if (underflow != 0) begin errors++; $display("[TB] FAIL underflow: got %0d pops on empty want 0", underflow); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL stray_beats: got %0d want 0", obs_q.size()); end
    checks++;
    if (rd_wide != 0) begin errors++; $display("[TB] FAIL rd_width_total: got %0d want 0", rd_wide); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_partial_flush();
    test_flush_empty();
    test_flush_capture();
    test_reset_capture();
    test_final();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
